// File: rtl/running_min_topk_if.sv
// Candidate stream in, sorted K-nearest snapshot out, for running_min_topk.
// The master side drives candidates and control pulses. The slave side publishes the snapshot.
interface running_min_topk_if #(
  parameter int DIST_WIDTH = 25,
  parameter int IDX_WIDTH  = 9,
  parameter int K          = 4
) ();
  logic                             restart;
  logic                             valid_in;
  logic [DIST_WIDTH-1:0]            dist_in;
  logic [IDX_WIDTH-1:0]             idx_in;
  logic                             finalize;
  logic                             out_valid;
  logic [K-1:0][DIST_WIDTH-1:0]     out_dist;
  logic [K-1:0][IDX_WIDTH-1:0]      out_idx;
  logic [K-1:0]                     out_entry_valid;

  // There is no backpressure. A candidate is taken in every cycle that valid_in is high.
  // out_valid is a one-cycle pulse, and out_* hold their values until the next pulse.
  modport master (
    output restart, valid_in, dist_in, idx_in, finalize,
    input  out_valid, out_dist, out_idx, out_entry_valid
  );
  modport slave (
    input  restart, valid_in, dist_in, idx_in, finalize,
    output out_valid, out_dist, out_idx, out_entry_valid
  );
endinterface

// File: rtl/running_min_topk.sv
// Keeps a sorted list of the K nearest candidates of the current query. It has two stages.
// Option macro RUNNING_MIN_DEDUP_EN: when defined, a candidate whose index is already in the list is discarded.
module running_min_topk #(
  parameter int DIST_WIDTH = 25,
  parameter int IDX_WIDTH  = 9,
  parameter int K          = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  running_min_topk_if.slave   bus
);

  logic                         restart_s1_q, valid_s1_q, finalize_s1_q;
  logic [DIST_WIDTH-1:0]        dist_s1_q;
  logic [IDX_WIDTH-1:0]         idx_s1_q;

  logic [K-1:0][DIST_WIDTH-1:0] dist_q, dist_d, dist_sh;
  logic [K-1:0][IDX_WIDTH-1:0]  idx_q, idx_d, idx_sh;
  logic [K-1:0]                 vld_q, vld_d, vld_live, vld_sh;
  logic [K-1:0]                 keep, prev_keep;
  logic                         dup, ins;

  logic                         out_valid_q, out_valid_d;
  logic [K-1:0][DIST_WIDTH-1:0] out_dist_q, out_dist_d;
  logic [K-1:0][IDX_WIDTH-1:0]  out_idx_q, out_idx_d;
  logic [K-1:0]                 out_ev_q, out_ev_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      restart_s1_q  <= 1'b0;
      valid_s1_q    <= 1'b0;
      finalize_s1_q <= 1'b0;
      dist_s1_q     <= '0;
      idx_s1_q      <= '0;
    end else begin
      restart_s1_q  <= bus.restart;
      valid_s1_q    <= bus.valid_in;
      finalize_s1_q <= bus.finalize;
      dist_s1_q     <= bus.dist_in;
      idx_s1_q      <= bus.idx_in;
    end
  end

  // Valid entries are sorted and sit at the front. Invalid entries fill the tail.
  // So keep[] is a run of ones followed by zeros, and the first zero is the insert slot.
  always_comb begin
    vld_live = restart_s1_q ? '0 : vld_q;
    for (int i = 0; i < K; i++) begin
      keep[i] = vld_live[i] && (dist_q[i] <= dist_s1_q);
    end
    prev_keep = {keep[K-2:0], 1'b1};
    dist_sh   = {dist_q[K-2:0], {DIST_WIDTH{1'b0}}};
    idx_sh    = {idx_q[K-2:0], {IDX_WIDTH{1'b0}}};
    vld_sh    = {vld_live[K-2:0], 1'b0};

    dup = 1'b0;
`ifdef RUNNING_MIN_DEDUP_EN
    for (int i = 0; i < K; i++) begin
      if (vld_live[i] && (idx_q[i] == idx_s1_q)) dup = 1'b1;
    end
`endif
    ins = valid_s1_q && !dup;

    dist_d = dist_q;
    idx_d  = idx_q;
    vld_d  = vld_live;
    if (ins) begin
      for (int i = 0; i < K; i++) begin
        if (!keep[i]) begin
          if (prev_keep[i]) begin
            dist_d[i] = dist_s1_q;
            idx_d[i]  = idx_s1_q;
            vld_d[i]  = 1'b1;
          end else begin
            dist_d[i] = dist_sh[i];
            idx_d[i]  = idx_sh[i];
            vld_d[i]  = vld_sh[i];
          end
        end
      end
    end

    out_valid_d = finalize_s1_q;
    out_dist_d  = out_dist_q;
    out_idx_d   = out_idx_q;
    out_ev_d    = out_ev_q;
    if (finalize_s1_q) begin
      for (int i = 0; i < K; i++) begin
        out_ev_d[i]   = vld_d[i];
        out_dist_d[i] = vld_d[i] ? dist_d[i] : '0;
        out_idx_d[i]  = vld_d[i] ? idx_d[i] : '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dist_q      <= '0;
      idx_q       <= '0;
      vld_q       <= '0;
      out_valid_q <= 1'b0;
      out_dist_q  <= '0;
      out_idx_q   <= '0;
      out_ev_q    <= '0;
    end else begin
      dist_q      <= dist_d;
      idx_q       <= idx_d;
      vld_q       <= vld_d;
      out_valid_q <= out_valid_d;
      out_dist_q  <= out_dist_d;
      out_idx_q   <= out_idx_d;
      out_ev_q    <= out_ev_d;
    end
  end

  assign bus.out_valid       = out_valid_q;
  assign bus.out_dist        = out_dist_q;
  assign bus.out_idx         = out_idx_q;
  assign bus.out_entry_valid = out_ev_q;

endmodule

// File: tb/tb_running_min_topk.sv
// Testbench for running_min_topk. It uses a reference list model and a queue of expected snapshots.
// Set RUNNING_MIN_DEDUP_EN to match the build of the design under test.
module tb_running_min_topk;
  localparam int DW = 25;
  localparam int IW = 9;
  localparam int K  = 4;
  localparam int PW = K + K*DW + K*IW;

  typedef struct {
    logic [DW-1:0] d;
    logic [IW-1:0] i;
  } ent_t;

  logic clk;
  logic rst_n;
  int   cyc;
  int   n_cmp;
  int   n_err;
  logic done;

  ent_t          m_q[$];
  logic [PW-1:0] exp_q[$];
  int            exp_cyc_q[$];
  logic [PW-1:0] last_exp;
  logic [PW-1:0] got;
  logic          exp_now;

  running_min_topk_if #(.DIST_WIDTH(DW), .IDX_WIDTH(IW), .K(K)) bus ();

  running_min_topk #(.DIST_WIDTH(DW), .IDX_WIDTH(IW), .K(K)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Clock and cycle counter.
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check_eq(input string tag, input logic [PW-1:0] got_v, input logic [PW-1:0] exp_v);
    n_cmp++;
    if (got_v !== exp_v) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got %h expected %h", tag, cyc, got_v, exp_v);
    end
  endtask

  // Reference list. A new sample goes after every entry whose distance is <= its own, then the list is cut to K entries.
  function automatic void model_insert(input logic [DW-1:0] d, input logic [IW-1:0] ix);
    ent_t e;
    int   pos;
`ifdef RUNNING_MIN_DEDUP_EN
    foreach (m_q[j]) if (m_q[j].i == ix) return;
`endif
    e.d = d;
    e.i = ix;
    pos = m_q.size();
    for (int j = m_q.size() - 1; j >= 0; j--) begin
      if (m_q[j].d > d) pos = j;
    end
    if (pos < K) begin
      m_q.insert(pos, e);
      if (m_q.size() > K) void'(m_q.pop_back());
    end
  endfunction

  function automatic logic [PW-1:0] model_snap();
    logic [K-1:0]         ev;
    logic [K-1:0][DW-1:0] ds;
    logic [K-1:0][IW-1:0] is;
    ev = '0;
    ds = '0;
    is = '0;
    for (int j = 0; j < K; j++) begin
      if (j < m_q.size()) begin
        ev[j] = 1'b1;
        ds[j] = m_q[j].d;
        is[j] = m_q[j].i;
      end
    end
    return {ev, ds, is};
  endfunction

  // Drives one cycle of stimulus and updates the model in the same order as the DUT: restart, then insert, then snapshot.
  task automatic drive(input logic r, input logic v, input logic [DW-1:0] d,
                       input logic [IW-1:0] ix, input logic f);
    @(posedge clk);
    #1;
    bus.restart  = r;
    bus.valid_in = v;
    bus.dist_in  = d;
    bus.idx_in   = ix;
    bus.finalize = f;
    if (r) m_q.delete();
    if (v) model_insert(d, ix);
    if (f) begin
      exp_q.push_back(model_snap());
      exp_cyc_q.push_back(cyc + 2);
    end
  endtask

  task automatic idle(input int n);
    for (int j = 0; j < n; j++) drive(1'b0, 1'b0, '0, '0, 1'b0);
  endtask

  task automatic pulse_reset();
    @(posedge clk);
    #1;
    bus.restart  = 1'b0;
    bus.valid_in = 1'b0;
    bus.dist_in  = '0;
    bus.idx_in   = '0;
    bus.finalize = 1'b0;
    rst_n = 1'b0;
    m_q.delete();
    exp_q.delete();
    exp_cyc_q.delete();
    last_exp = '0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic scen_basic();
    drive(1'b1, 1'b0, '0, '0, 1'b0);
    drive(1'b0, 1'b1, 25'd50, 9'd0, 1'b0);
    drive(1'b0, 1'b1, 25'd10, 9'd1, 1'b0);
    drive(1'b0, 1'b1, 25'd30, 9'd2, 1'b0);
    drive(1'b0, 1'b1, 25'd20, 9'd3, 1'b0);
    drive(1'b0, 1'b1, 25'd40, 9'd4, 1'b1);
    idle(3);
  endtask

  // Scoreboard monitor. It checks out_valid every cycle, compares the snapshot on a pulse, and checks that outputs hold otherwise.
  always @(negedge clk) begin
    if (!done) begin
      got     = {bus.out_entry_valid, bus.out_dist, bus.out_idx};
      exp_now = (exp_cyc_q.size() > 0) && (exp_cyc_q[0] == cyc);
      check_eq("out_valid", {{(PW-1){1'b0}}, bus.out_valid}, {{(PW-1){1'b0}}, exp_now});
      if (exp_now) begin
        last_exp = exp_q.pop_front();
        void'(exp_cyc_q.pop_front());
        check_eq("snapshot", got, last_exp);
      end else begin
        check_eq("hold", got, last_exp);
      end
    end
  end

  initial begin
    n_cmp        = 0;
    n_err        = 0;
    cyc          = 0;
    done         = 1'b0;
    last_exp     = '0;
    rst_n        = 1'b0;
    bus.restart  = 1'b0;
    bus.valid_in = 1'b0;
    bus.dist_in  = '0;
    bus.idx_in   = '0;
    bus.finalize = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(2);

    // Five samples, with finalize on the last one.
    scen_basic();

    // Two samples give a partially filled list.
    drive(1'b1, 1'b0, '0, '0, 1'b0);
    drive(1'b0, 1'b1, 25'd9, 9'd7, 1'b0);
    drive(1'b0, 1'b1, 25'd3, 9'd8, 1'b1);
    idle(3);

    // Equal distances keep arrival order. An all-ones distance is a real candidate.
    drive(1'b1, 1'b0, '0, '0, 1'b0);
    drive(1'b0, 1'b1, 25'd7, 9'd5, 1'b0);
    drive(1'b0, 1'b1, 25'd7, 9'd2, 1'b0);
    drive(1'b0, 1'b1, {DW{1'b1}}, 9'd6, 1'b1);
    idle(3);

    // Fill the list, then restart in the same cycle as a valid sample and a finalize.
    drive(1'b1, 1'b1, 25'd10, 9'd0, 1'b0);
    drive(1'b0, 1'b1, 25'd20, 9'd1, 1'b0);
    drive(1'b0, 1'b1, 25'd30, 9'd2, 1'b0);
    drive(1'b0, 1'b1, 25'd40, 9'd3, 1'b1);
    drive(1'b1, 1'b1, 25'd99, 9'd3, 1'b1);
    idle(3);

    // Repeated index.
    drive(1'b1, 1'b0, '0, '0, 1'b0);
    drive(1'b0, 1'b1, 25'd5, 9'd4, 1'b0);
    drive(1'b0, 1'b1, 25'd1, 9'd4, 1'b1);
    idle(3);

    // Back-to-back finalize, finalize without restart (the list keeps growing), and an empty restart+finalize.
    drive(1'b0, 1'b1, 25'd2, 9'd9, 1'b1);
    drive(1'b0, 1'b1, 25'd0, 9'd10, 1'b1);
    drive(1'b0, 1'b0, '0, '0, 1'b1);
    drive(1'b1, 1'b0, '0, '0, 1'b1);
    idle(3);

    // Reset one cycle after a finalize. No pulse may follow, and the next query must behave like a fresh one.
    drive(1'b1, 1'b1, 25'd8, 9'd1, 1'b0);
    drive(1'b0, 1'b1, 25'd4, 9'd2, 1'b1);
    pulse_reset();
    idle(3);
    scen_basic();

    // Random stimulus. Distances are drawn from a narrow range so that ties are frequent.
    for (int n = 0; n < 400; n++) begin
      drive(($urandom_range(0, 19) == 0), ($urandom_range(0, 3) != 0),
            DW'($urandom_range(0, 15)), IW'($urandom_range(0, 11)),
            ($urandom_range(0, 5) == 0));
    end
    idle(4);

    done = 1'b1;
    check_eq("pending", PW'(exp_q.size()), '0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
